// File: rtl/score_counter.sv
// Saturating 0..SCORE_MAX game score with IDLE/RUN/OVER phase tracking, one-cycle update latency.
// Optional registered bonus-life pulse one_up_o compiled in with `define SCORE_ONE_UP_EN.
module score_counter #(
    parameter int COIN_PTS  = 1,
    parameter int STOMP_PTS = 2,
    parameter int SCORE_MAX = 99
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       game_start_i,
    input  logic       game_over_i,
    input  logic       coin_hit_i,
    input  logic       stomp_hit_i,
    output logic [6:0] score_o,
    output logic       running_o,
    output logic       score_full_o
`ifdef SCORE_ONE_UP_EN
    ,
    output logic       one_up_o
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    localparam logic [7:0] COIN_W  = 8'(COIN_PTS);
    localparam logic [7:0] STOMP_W = 8'(STOMP_PTS);
    localparam logic [6:0] MAX_W   = 7'(SCORE_MAX);

    logic [1:0] state_q, state_d;
    logic [6:0] score_q, score_d;
    logic       start_prev_q, over_prev_q, coin_prev_q, stomp_prev_q;
    logic       start_edge, over_edge, coin_edge, stomp_edge;
    logic [7:0] sum;

    assign start_edge = game_start_i & ~start_prev_q;
    assign over_edge  = game_over_i  & ~over_prev_q;
    assign coin_edge  = coin_hit_i   & ~coin_prev_q;
    assign stomp_edge = stomp_hit_i  & ~stomp_prev_q;

    assign sum = {1'b0, score_q} + (coin_edge ? COIN_W : 8'd0) + (stomp_edge ? STOMP_W : 8'd0);

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        if (start_edge) begin
            state_d = ST_RUN;
            score_d = 7'd0;
        end else if (state_q == ST_RUN) begin
            // Hits arriving with a game_over edge still count.
            score_d = (sum > {1'b0, MAX_W}) ? MAX_W : sum[6:0];
            if (over_edge) begin
                state_d = ST_OVER;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            score_q      <= 7'd0;
            start_prev_q <= 1'b0;
            over_prev_q  <= 1'b0;
            coin_prev_q  <= 1'b0;
            stomp_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            start_prev_q <= game_start_i;
            over_prev_q  <= game_over_i;
            coin_prev_q  <= coin_hit_i;
            stomp_prev_q <= stomp_hit_i;
        end
    end

    assign score_o      = score_q;
    assign running_o    = (state_q == ST_RUN);
    assign score_full_o = (score_q == MAX_W);

`ifdef SCORE_ONE_UP_EN
    logic armed_q, armed_d;
    logic one_up_q, one_up_d;

    always_comb begin
        armed_d  = armed_q;
        one_up_d = 1'b0;
        if (start_edge) begin
            armed_d = 1'b1;
        end else if (state_q == ST_RUN && armed_q && score_q < 7'd50 && score_d >= 7'd50) begin
            one_up_d = 1'b1;
            armed_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            armed_q  <= 1'b0;
            one_up_q <= 1'b0;
        end else begin
            armed_q  <= armed_d;
            one_up_q <= one_up_d;
        end
    end

    assign one_up_o = one_up_q;
`endif

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: vector table, directed corner sequences and random stimulus vs. a score model.
module tb_score_counter;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       game_start_i, game_over_i, coin_hit_i, stomp_hit_i;
    logic [6:0] score_o;
    logic       running_o, score_full_o;
`ifdef SCORE_ONE_UP_EN
    logic       one_up_o;
`endif

    score_counter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .game_start_i (game_start_i),
        .game_over_i  (game_over_i),
        .coin_hit_i   (coin_hit_i),
        .stomp_hit_i  (stomp_hit_i),
        .score_o      (score_o),
        .running_o    (running_o),
        .score_full_o (score_full_o)
`ifdef SCORE_ONE_UP_EN
        ,
        .one_up_o     (one_up_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: game phase 0=idle 1=run 2=over
    int m_phase;
    int m_score;
    bit m_prev_gs, m_prev_go, m_prev_c, m_prev_s;
`ifdef SCORE_ONE_UP_EN
    bit m_bonus_avail;
    bit m_one_up;
`endif

    typedef struct {
        logic gs, go, coin, stomp;
        int   score;
        logic run;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_score = 0;
        m_prev_gs = 0; m_prev_go = 0; m_prev_c = 0; m_prev_s = 0;
`ifdef SCORE_ONE_UP_EN
        m_bonus_avail = 0;
        m_one_up = 0;
`endif
    endtask

    task automatic model_step(input bit gs, input bit go, input bit c, input bit s);
        bit e_gs, e_go, e_c, e_s;
        int next;
        e_gs = gs && !m_prev_gs;
        e_go = go && !m_prev_go;
        e_c  = c  && !m_prev_c;
        e_s  = s  && !m_prev_s;
`ifdef SCORE_ONE_UP_EN
        m_one_up = 0;
`endif
        if (e_gs) begin
            m_phase = 1;
            m_score = 0;
`ifdef SCORE_ONE_UP_EN
            m_bonus_avail = 1;
`endif
        end else if (m_phase == 1) begin
            next = m_score + (e_c ? 1 : 0) + (e_s ? 2 : 0);
            if (next > 99) next = 99;
`ifdef SCORE_ONE_UP_EN
            if (m_bonus_avail && m_score < 50 && next >= 50) begin
                m_one_up = 1;
                m_bonus_avail = 0;
            end
`endif
            m_score = next;
            if (e_go) m_phase = 2;
        end
        m_prev_gs = gs; m_prev_go = go; m_prev_c = c; m_prev_s = s;
    endtask

    task automatic cycle(input bit gs, input bit go, input bit c, input bit s);
        @(negedge clk_i);
        game_start_i = gs;
        game_over_i  = go;
        coin_hit_i   = c;
        stomp_hit_i  = s;
        model_step(gs, go, c, s);
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_model();
        chk("score_vs_model", int'(score_o), m_score);
        chk("running_vs_model", int'(running_o), (m_phase == 1) ? 1 : 0);
        chk("full_vs_model", int'(score_full_o), (m_score == 99) ? 1 : 0);
`ifdef SCORE_ONE_UP_EN
        chk("one_up_vs_model", int'(one_up_o), int'(m_one_up));
`endif
    endtask

    task automatic stomp_pulse();
        cycle(0, 0, 0, 1);
        check_model();
        cycle(0, 0, 0, 0);
    endtask

    initial begin
        vecs[0]  = '{gs:0, go:0, coin:0, stomp:0, score:0, run:0};
        vecs[1]  = '{gs:1, go:0, coin:0, stomp:0, score:0, run:1};
        vecs[2]  = '{gs:0, go:0, coin:1, stomp:0, score:1, run:1};
        vecs[3]  = '{gs:0, go:0, coin:1, stomp:0, score:1, run:1};
        vecs[4]  = '{gs:0, go:0, coin:1, stomp:0, score:1, run:1};
        vecs[5]  = '{gs:0, go:0, coin:1, stomp:0, score:1, run:1};
        vecs[6]  = '{gs:0, go:0, coin:1, stomp:0, score:1, run:1};
        vecs[7]  = '{gs:0, go:0, coin:0, stomp:0, score:1, run:1};
        vecs[8]  = '{gs:0, go:0, coin:1, stomp:1, score:4, run:1};
        vecs[9]  = '{gs:0, go:0, coin:0, stomp:0, score:4, run:1};
        vecs[10] = '{gs:0, go:1, coin:0, stomp:0, score:4, run:0};
        vecs[11] = '{gs:0, go:0, coin:1, stomp:0, score:4, run:0};
        vecs[12] = '{gs:0, go:1, coin:0, stomp:0, score:4, run:0};
        vecs[13] = '{gs:1, go:0, coin:0, stomp:0, score:0, run:1};

        rst_i = 1'b1;
        game_start_i = 0; game_over_i = 0; coin_hit_i = 0; stomp_hit_i = 0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_score", int'(score_o), 0);
        chk("reset_running", int'(running_o), 0);
        chk("reset_full", int'(score_full_o), 0);
`ifdef SCORE_ONE_UP_EN
        chk("reset_one_up", int'(one_up_o), 0);
`endif
        @(negedge clk_i);
        rst_i = 1'b0;

        // Start, held coin, simultaneous hits, game over, ignored events, restart
        foreach (vecs[i]) begin
            cycle(vecs[i].gs, vecs[i].go, vecs[i].coin, vecs[i].stomp);
            chk($sformatf("vec%0d_score", i), int'(score_o), vecs[i].score);
            chk($sformatf("vec%0d_running", i), int'(running_o), int'(vecs[i].run));
        end

        // Game over together with a coin at score 10
        cycle(0, 0, 0, 0);
        for (int k = 0; k < 5; k++) stomp_pulse();
        chk("pre_over_score", int'(score_o), 10);
        cycle(0, 1, 1, 0);
        chk("over_coin_score", int'(score_o), 11);
        chk("over_running", int'(running_o), 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        chk("over_hold_coin", int'(score_o), 11);
        cycle(0, 0, 0, 1);
        chk("over_hold_stomp", int'(score_o), 11);
        cycle(1, 0, 0, 0);
        chk("restart_score", int'(score_o), 0);
        chk("restart_running", int'(running_o), 1);
        cycle(0, 0, 0, 0);

        // Start edge beats a simultaneous stomp
        for (int k = 0; k < 15; k++) stomp_pulse();
        chk("pre_prio_score", int'(score_o), 30);
        cycle(1, 0, 0, 1);
        chk("prio_score", int'(score_o), 0);
        chk("prio_running", int'(running_o), 1);
        cycle(0, 0, 0, 0);

        // Saturation over 60 stomp edges
        for (int k = 1; k <= 60; k++) begin
            cycle(0, 0, 0, 1);
            if (k == 49) begin
                chk("sat49_score", int'(score_o), 98);
                chk("sat49_full", int'(score_full_o), 0);
            end
            if (k == 50) begin
                chk("sat50_score", int'(score_o), 99);
                chk("sat50_full", int'(score_full_o), 1);
            end
            if (k == 60) begin
                chk("sat60_score", int'(score_o), 99);
                chk("sat60_full", int'(score_full_o), 1);
            end
            cycle(0, 0, 0, 0);
        end

        // Asynchronous reset mid-cycle
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_score", int'(score_o), 0);
        chk("async_rst_running", int'(running_o), 0);
        chk("async_rst_full", int'(score_full_o), 0);
        game_start_i = 0; game_over_i = 0; coin_hit_i = 0; stomp_hit_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_model();
        end

`ifdef SCORE_ONE_UP_EN
        // Bonus life: 49 -> 51 fires once, re-arms on restart
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        for (int k = 0; k < 24; k++) stomp_pulse();
        cycle(0, 0, 1, 0);
        chk("oneup_pre_score", int'(score_o), 49);
        chk("oneup_pre_pulse", int'(one_up_o), 0);
        cycle(0, 0, 0, 1);
        chk("oneup_jump_score", int'(score_o), 51);
        chk("oneup_jump_pulse", int'(one_up_o), 1);
        cycle(0, 0, 0, 0);
        chk("oneup_width", int'(one_up_o), 0);
        for (int k = 0; k < 5; k++) stomp_pulse();
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        for (int k = 0; k < 24; k++) stomp_pulse();
        cycle(0, 0, 0, 1);
        chk("oneup_rearm_score", int'(score_o), 50);
        chk("oneup_rearm_pulse", int'(one_up_o), 1);
        cycle(0, 0, 0, 0);
        check_model();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/score_counter.md
# score_counter

Game-score accumulator sitting directly upstream of the two-digit seven-segment score display. It turns one-cycle-or-longer collision indications (coin collected, enemy stomped) into a saturating binary score of 0–99. It also tracks game phase (idle / running / over), so the score resets at each new game and freezes after game over. Its `score` output drives the display's 7-bit `score` input directly.

## Interface

Parameters:
- `COIN_PTS`, default 1: points added per coin event.
- `STOMP_PTS`, default 2: points added per stomp event.
- `SCORE_MAX`, default 99: saturation ceiling. Must be ≤ 99, because the display shows two decimal digits.

Ports:
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `game_start` input 1: level, synchronous to `clk`. A rising edge starts or restarts a game.
- `game_over` input 1: level, synchronous. A rising edge ends the current game.
- `coin_hit` input 1: level from collision logic; may stay high for several cycles.
- `stomp_hit` input 1: level from collision logic; may stay high for several cycles.
- `score` output 7: current score, binary, range 0..`SCORE_MAX`.
- `running` output 1: high while in state RUN.
- `score_full` output 1: high when `score == SCORE_MAX`.
- `one_up` output 1: bonus-life pulse. Present only with `SCORE_ONE_UP_EN`.

## Operation

- **Edge detection.** Each of the four level inputs has a previous-value register.
  - A rising edge is `in & ~prev`.
  - The `prev` registers update every cycle in every state.
  - A line held high therefore produces exactly one event, even across state changes.
- **State machine.** Registered, three states: IDLE, RUN, OVER.
  - IDLE → RUN on a `game_start` edge.
  - RUN → RUN (restart) on a `game_start` edge.
  - RUN → OVER on a `game_over` edge.
  - OVER → RUN on a `game_start` edge.
  - Every entry into RUN, including restart, loads `score = 0`.
- **Scoring.** Scoring happens only in RUN.
  - Per cycle, increment = (coin edge ? `COIN_PTS` : 0) + (stomp edge ? `STOMP_PTS` : 0).
  - Coin and stomp edges in the same cycle are both credited.
  - Compute the sum at 8 bits. If the sum exceeds `SCORE_MAX`, load `SCORE_MAX` (saturate; never wrap).
- **Ignored events.**
  - In IDLE and OVER, hit edges are discarded and `score` holds.
  - A `game_over` edge in IDLE or OVER is ignored.
- **Priority within one cycle:** `game_start` edge > `game_over` edge > hits.
  - `game_start` edge together with hits: score becomes 0 and the hits are dropped.
  - `game_over` edge together with hits in RUN: the hits are credited on that same edge and the state moves to OVER.
- **Status outputs.** `running` and `score_full` are combinational decodes of registered state.

## Timing

- **Reset values:**
  - state = IDLE, `score` = 0, `running` = 0, `score_full` = 0, `one_up` = 0.
  - All `prev` registers = 0.
- **Reset mid-game:** the block returns to IDLE immediately, asynchronously. The score is lost.
- **Latency:** if a hit line is first sampled high at edge N, the updated `score` is visible after edge N, i.e. one-cycle latency.
- **Event rate:** back-to-back events are not lost. Each rising edge is handled in the cycle it is detected; there is no internal queue and none is needed.
- **Restart latency:** a `game_start` edge at edge N gives `running` = 1 and `score` = 0 after edge N.
- **Saturated state:** once `score` = `SCORE_MAX`, further hits leave it unchanged and `score_full` stays 1 until a restart.

## Configuration

`SCORE_ONE_UP_EN` compiles the `one_up` output in or out.

With `SCORE_ONE_UP_EN` defined:
- `one_up` is a registered single-cycle pulse.
- It fires on the edge where `score` first goes from < 50 to ≥ 50 within a game.
- It fires at most once per game. An armed flag is set on RUN entry and cleared when the pulse fires.
- A jump from 49 to 51 (stomp) also fires.

Without `SCORE_ONE_UP_EN`:
- The port and the armed flag do not exist.
- All other behaviour is identical.

## Test plan

- **Reset, then start.** Hold `rst` 3 cycles, release, then pulse `game_start`.
  - During reset and before the start: `score` = 0, `running` = 0.
  - One cycle after the `game_start` edge: `running` = 1.
- **Held hit and simultaneous hits.** In RUN, hold `coin_hit` high 5 cycles → `score` = 1 (single event). Then coin and stomp edges in the same cycle → `score` = 4.
- **Saturation.** Run 60 stomp edges from 0.
  - `score` reads 98 after 49 events, then 99 after the 50th, and stays 99.
  - `score_full` = 1; no wrap occurs.
- **Game over and restart.**
  - `game_over` edge at score 10 together with a coin edge → `score` = 11, state OVER.
  - Further hits leave `score` at 11.
  - A `game_start` edge → `score` = 0, `running` = 1.
- **Priority and async reset.**
  - `game_start` and stomp edges in the same cycle at score 30 → `score` = 0.
  - Assert `rst` mid-cycle in RUN → outputs go to reset values without waiting for a clock edge.
- **With `SCORE_ONE_UP_EN` defined.**
  - Score 49 plus a stomp → `score` = 51 and `one_up` high for exactly 1 cycle.
  - Further crossings of 50 in the same game give no pulse.
  - After a restart, the next crossing of 50 pulses again.
